from_8bit: RTL and testbench
============================

Name: from_8bit

Overview:
- Downstream companion of the 8-bit narrowing stage: consumes the byte stream that stage produces and rebuilds 8/16/32-bit words.
- Runs on the single byte-rate clock.
- Selects word width with the same 2-bit dataS code as the narrowing stage.
- Emits a one-cycle valid pulse per rebuilt word and flags alignment errors.

Parameters:
- BYTE_W, 8, byte width (fixed; not intended for override).
- MSB_FIRST, 1, 1 = first byte received becomes the most significant byte; 0 = least significant first.

Ports:
- clk  input  1  byte-rate clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  global enable; 0 freezes all state.
- validIn  input  1  dataIn carries a byte this cycle.
- dataIn  input  8  incoming byte.
- dataS  input  2  width select: 00 = 8, 01 = 16, 10 = 32, 11 = reserved.
- dataOut  output  32  rebuilt word, zero-extended to 32 bits.
- dataSOut  output  2  width code of the word on dataOut.
- validOut  output  1  one-cycle pulse: dataOut/dataSOut are new.
- errOut  output  1  one-cycle pulse: partial word discarded.

Behaviour:
- Reset (rst = 0, asynchronous):
  - dataOut = 0, dataSOut = 00, validOut = 0, errOut = 0.
  - Internal byte counter cnt[1:0] = 0, accumulator acc[31:0] = 0, latched width wS = 00.
- All other updates happen on the rising edge of clk.
- enb = 0: cnt, acc, wS, dataOut and dataSOut hold; validOut and errOut are 0 at the next edge.
- Word length N = 1, 2, 4 for dataS = 00, 01, 10.
- Byte accept: condition is enb & validIn & dataS != 11.
  - MSB_FIRST = 1: acc <= {acc[23:0], dataIn}.
  - MSB_FIRST = 0: the byte is placed at lane cnt.
- Word completion: a byte accepted with cnt == N-1 completes the word.
  - Next edge: dataOut <= assembled word masked to N bytes; dataSOut <= wS; validOut <= 1; cnt <= 0.
  - Latency: validOut is high in the cycle after the edge that accepts the last byte.
- Non-final byte: cnt <= cnt + 1, validOut <= 0.
- validIn = 0 with enb = 1: no change to cnt or acc; validOut <= 0. Gaps between bytes are allowed.
- Width change (dataS != wS on an accepting edge):
  - wS <= dataS; the current partial word is discarded.
  - The current byte becomes byte 0 of the new word, so cnt <= 1, or the word completes at once if N = 1.
  - errOut <= 1 if cnt != 0 before the change, otherwise errOut <= 0.
- dataS = 11 with validIn = 1: byte dropped, cnt <= 0, errOut <= 1 if cnt != 0; no validOut.
- Simultaneous completion and width change: the width change wins. The old partial word is never output.
- dataOut holds the last word between validOut pulses.
- Reset mid-word: the partial word is lost; no pulse on errOut or validOut.
- Counter wrap: cnt never exceeds N-1. Mode 8 keeps cnt at 0.

Decomposition:
- Shared package:
  - Width codes WIDTH_8 = 2'b00, WIDTH_16 = 2'b01, WIDTH_32 = 2'b10, WIDTH_RSV = 2'b11.
  - Function width_to_bytes(code) returning N.
  - The narrowing stage reuses the same constants.
- Single module. No sub-module is natural: the counter, accumulator and output register are one tightly coupled datapath.
- The bench pairs this block with the narrowing stage (loopback) in the existing clock/test harness.
- A synthesized variant named from_8bitSynth must pass the same bench.

Test Plan:
- Reset then idle: hold rst = 0 for 40 ns, release; validIn = 0 for 5 cycles -> dataOut = 0, validOut = 0, errOut = 0 throughout.
- 8-bit mode: dataS = 00, bytes FF, 00, F0, 0F, 9A on consecutive cycles -> five validOut pulses, dataOut = 000000FF, 00000000, 000000F0, 0000000F, 0000009A, each one cycle after its byte.
- 16-bit mode, MSB_FIRST = 1: dataS = 01, bytes AD, 43, 54, 3F -> validOut pulses after 43 and after 3F; dataOut = 0000AD43 then 0000543F; dataSOut = 01.
- 32-bit mode with gaps: dataS = 10, bytes 95, FD, AD, 43 with validIn = 0 for 2 cycles between FD and AD -> single pulse, dataOut = 95FDAD43.
- Mid-word width change: dataS = 10, bytes 94, D5; then dataS = 01, bytes 54, 3F -> errOut pulse on the edge accepting 54; dataOut = 0000543F, dataSOut = 01; the 94D5 partial word is never output.
- enb and reset mid-word: dataS = 10, bytes 03, 78; enb = 0 for 3 cycles (no output change); enb = 1, bytes FD, AE -> dataOut = 0378FDAE. Repeat with rst = 0 after 2 bytes -> no validOut; the next 4 bytes form a fresh word.

Source files
------------

// File: rtl/from_8bit_pkg.sv
// from_8bit_pkg: width codes and helpers shared by the 8-bit narrowing and widening stages.
package from_8bit_pkg;
    localparam logic [1:0] WIDTH_8   = 2'b00;
    localparam logic [1:0] WIDTH_16  = 2'b01;
    localparam logic [1:0] WIDTH_32  = 2'b10;
    localparam logic [1:0] WIDTH_RSV = 2'b11;

    function automatic logic [2:0] width_to_bytes(input logic [1:0] code);
        return code == WIDTH_32 ? 3'd4 : code == WIDTH_16 ? 3'd2 : 3'd1;
    endfunction

    function automatic logic [31:0] byteMask(input logic [1:0] code);
        return code == WIDTH_32 ? 32'hFFFF_FFFF : code == WIDTH_16 ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction
endpackage

// File: rtl/from_8bit.sv
// from_8bit: rebuilds 8/16/32-bit words from a byte stream, pulsing validOut per word
// and errOut whenever a partial word is thrown away.
module from_8bit
    import from_8bit_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              validIn,
    input  logic [BYTE_W-1:0] dataIn,
    input  logic [1:0]        dataS,
    output logic [31:0]       dataOut,
    output logic [1:0]        dataSOut,
    output logic              validOut,
    output logic              errOut
);
    logic [1:0]  cnt, wS, lane;
    logic [31:0] acc, base, nextAcc;
    logic        accept, change, last;

    always_comb begin
        accept  = enb & validIn & (dataS != WIDTH_RSV);
        change  = dataS != wS;
        // a width change restarts the word with the current byte as byte 0
        lane    = change ? 2'd0 : cnt;
        last    = {1'b0, lane} == width_to_bytes(dataS) - 3'd1;
        base    = lane == 2'd0 ? 32'd0 : acc;
        nextAcc = MSB_FIRST ? {acc[23:0], dataIn} : base | (32'(dataIn) << {lane, 3'b000});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 2'd0;
            acc      <= 32'd0;
            wS       <= WIDTH_8;
            dataOut  <= 32'd0;
            dataSOut <= WIDTH_8;
            validOut <= 1'b0;
            errOut   <= 1'b0;
        end else begin
            validOut <= 1'b0;
            errOut   <= 1'b0;
            if (accept) begin
                acc    <= nextAcc;
                wS     <= dataS;
                errOut <= change && cnt != 2'd0;
                cnt    <= last ? 2'd0 : lane + 2'd1;
                if (last) begin
                    dataOut  <= nextAcc & byteMask(dataS);
                    dataSOut <= dataS;
                    validOut <= 1'b1;
                end
            end else if (enb && validIn) begin
                cnt    <= 2'd0;
                errOut <= cnt != 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_from_8bit.sv
// tb_from_8bit: directed byte sequences with a scoreboard of expected words.
module tb_from_8bit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enb = 1'b0;
    logic        validIn = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic [1:0]  dataS = 2'b00;
    logic [31:0] dataOut;
    logic [1:0]  dataSOut;
    logic        validOut, errOut;

    logic [33:0] sb[$];
    logic [33:0] lastExp = 34'd0;
    int          passes = 0, total = 0;

    from_8bit dut (
        .clk(clk), .rst(rst), .enb(enb), .validIn(validIn), .dataIn(dataIn), .dataS(dataS),
        .dataOut(dataOut), .dataSOut(dataSOut), .validOut(validOut), .errOut(errOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // drive one cycle, then check the outputs produced by that edge
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] s, input logic e,
                        input logic expErr, input logic push, input logic [31:0] w);
        enb = e; validIn = v; dataIn = d; dataS = s;
        if (push) sb.push_back({s, w});
        @(posedge clk);
        #1;
        chk("errOut", 34'(errOut), 34'(expErr));
        chk("validOut", 34'(validOut), 34'(sb.size() != 0));
        if (validOut && sb.size() != 0) lastExp = sb.pop_front();
        chk("dataOut", 34'(dataOut), 34'(lastExp[31:0]));
        chk("dataSOut", 34'(dataSOut), 34'(lastExp[33:32]));
    endtask

    initial begin
        #40;
        chk("resetDataOut", 34'(dataOut), 34'd0);
        chk("resetValid", 34'({validOut, errOut}), 34'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step(0, 8'h00, 2'b00, 1, 0, 0, 0);
        // 8-bit mode
        step(1, 8'hFF, 2'b00, 1, 0, 1, 32'h0000_00FF);
        step(1, 8'h00, 2'b00, 1, 0, 1, 32'h0000_0000);
        step(1, 8'hF0, 2'b00, 1, 0, 1, 32'h0000_00F0);
        step(1, 8'h0F, 2'b00, 1, 0, 1, 32'h0000_000F);
        step(1, 8'h9A, 2'b00, 1, 0, 1, 32'h0000_009A);
        // 16-bit mode
        step(1, 8'hAD, 2'b01, 1, 0, 0, 0);
        step(1, 8'h43, 2'b01, 1, 0, 1, 32'h0000_AD43);
        step(1, 8'h54, 2'b01, 1, 0, 0, 0);
        step(1, 8'h3F, 2'b01, 1, 0, 1, 32'h0000_543F);
        // 32-bit with gaps
        step(1, 8'h95, 2'b10, 1, 0, 0, 0);
        step(1, 8'hFD, 2'b10, 1, 0, 0, 0);
        step(0, 8'h11, 2'b10, 1, 0, 0, 0);
        step(0, 8'h22, 2'b10, 1, 0, 0, 0);
        step(1, 8'hAD, 2'b10, 1, 0, 0, 0);
        step(1, 8'h43, 2'b10, 1, 0, 1, 32'h95FD_AD43);
        // mid-word width change discards 94D5
        step(1, 8'h94, 2'b10, 1, 0, 0, 0);
        step(1, 8'hD5, 2'b10, 1, 0, 0, 0);
        step(1, 8'h54, 2'b01, 1, 1, 0, 0);
        step(1, 8'h3F, 2'b01, 1, 0, 1, 32'h0000_543F);
        // enable freeze mid-word, including bytes offered while frozen
        step(1, 8'h03, 2'b10, 1, 0, 0, 0);
        step(1, 8'h78, 2'b10, 1, 0, 0, 0);
        step(1, 8'hEE, 2'b10, 0, 0, 0, 0);
        step(0, 8'h00, 2'b00, 0, 0, 0, 0);
        step(1, 8'h55, 2'b11, 0, 0, 0, 0);
        step(1, 8'hFD, 2'b10, 1, 0, 0, 0);
        step(1, 8'hAE, 2'b10, 1, 0, 1, 32'h0378_FDAE);
        // reserved code drops the byte and the partial word
        step(1, 8'h11, 2'b10, 1, 0, 0, 0);
        step(1, 8'h22, 2'b10, 1, 0, 0, 0);
        step(1, 8'h33, 2'b11, 1, 1, 0, 0);
        step(1, 8'hA1, 2'b10, 1, 0, 0, 0);
        step(1, 8'hB2, 2'b10, 1, 0, 0, 0);
        step(1, 8'hC3, 2'b10, 1, 0, 0, 0);
        step(1, 8'hD4, 2'b10, 1, 0, 1, 32'hA1B2_C3D4);
        // reset mid-word
        step(1, 8'h03, 2'b10, 1, 0, 0, 0);
        step(1, 8'h78, 2'b10, 1, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("midResetDataOut", 34'(dataOut), 34'd0);
        chk("midResetFlags", 34'({validOut, errOut, dataSOut}), 34'd0);
        lastExp = 34'd0;
        @(negedge clk);
        rst = 1'b1;
        step(1, 8'h12, 2'b10, 1, 0, 0, 0);
        step(1, 8'h34, 2'b10, 1, 0, 0, 0);
        step(1, 8'h56, 2'b10, 1, 0, 0, 0);
        step(1, 8'h78, 2'b10, 1, 0, 1, 32'h1234_5678);
        step(0, 8'h00, 2'b10, 1, 0, 0, 0);
        chk("scoreboardEmpty", 34'(sb.size()), 34'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
